// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its consumer (decode):
// bubble encoding, NOP word, FSM state encodings and the if_id record.
package fetch_pkg;

    localparam logic [31:0] NOP_INS   = 32'h0000_0013;
    localparam logic [31:0] BUBBLE_PC = 32'hffff_ffff;

    typedef enum logic [2:0] {
        ST_REQ      = 3'd0,
        ST_WAIT     = 3'd1,
        ST_FULL     = 3'd2,
        ST_KILL     = 3'd3,
        ST_MISALIGN = 3'd4,
        ST_TRAP     = 3'd5
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        misalign;
    } if_id_t;

    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.ins      = NOP_INS;
        b.pc       = BUBBLE_PC;
        b.misalign = 1'b0;
        return b;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage. Holds the PC, keeps at most one imem request in
// flight, buffers a response that arrives while decode is stalled, and
// presents instructions, bubbles and misaligned-fetch markers on if_id__*.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_flush,
    input  logic [31:0] jump_target,
    input  logic        data_hazard,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id__ins,
    output logic [31:0] if_id__pc,
    output logic        if_id__ins_misalign
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_ins_q, buf_ins_d;
    if_id_t       if_id_q, if_id_d;
    logic [31:0]  pc_plus4;
    logic         owed;

    assign pc_plus4 = pc_q + 32'd4;

    // A response is still owed if we are waiting without it arriving now, or
    // the request is being accepted in this very cycle, or a kill is pending.
    assign owed = ((state_q == ST_WAIT) && !imem_rvalid) ||
                  ((state_q == ST_REQ)  && imem_ready)   ||
                  ((state_q == ST_KILL) && !imem_rvalid);

    // Next-state, next-PC, skid buffer and if_id register updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_ins_d = buf_ins_q;
        if_id_d   = data_hazard ? if_id_q : if_id_bubble();

        if (pipe_flush) begin
            // Flush overrides the stall: drop everything and redirect.
            if_id_d = if_id_bubble();
            pc_d    = jump_target;
            if (owed) begin
                state_d = ST_KILL;
            end else if (is_misaligned(jump_target)) begin
                state_d = ST_MISALIGN;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (!data_hazard) begin
                            if_id_d.ins      = imem_rdata;
                            if_id_d.pc       = pc_q;
                            if_id_d.misalign = 1'b0;
                            pc_d             = pc_plus4;
                            state_d          = is_misaligned(pc_plus4) ? ST_MISALIGN : ST_REQ;
                        end else begin
                            // Decode is stalled: park the word until it frees up.
                            buf_ins_d = imem_rdata;
                            state_d   = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (!data_hazard) begin
                        if_id_d.ins      = buf_ins_q;
                        if_id_d.pc       = pc_q;
                        if_id_d.misalign = 1'b0;
                        pc_d             = pc_plus4;
                        state_d          = ST_REQ;
                    end
                end
                ST_KILL: begin
                    // The stale response is swallowed; then fetch from the new PC.
                    if (imem_rvalid) begin
                        state_d = is_misaligned(pc_q) ? ST_MISALIGN : ST_REQ;
                    end
                end
                ST_MISALIGN: begin
                    if (!data_hazard) begin
                        if_id_d.ins      = NOP_INS;
                        if_id_d.pc       = pc_q;
                        if_id_d.misalign = 1'b1;
                        state_d          = ST_TRAP;
                    end
                end
                ST_TRAP: begin
                    state_d = ST_TRAP;
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    // Control and output registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_VECTOR;
            if_id_q <= if_id_bubble();
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    // Skid buffer contents are only meaningful in ST_FULL, so no reset needed.
    always_ff @(posedge clk) begin
        buf_ins_q <= buf_ins_d;
    end

    assign imem_req            = !rst && (state_q == ST_REQ);
    assign imem_addr           = pc_q;
    assign if_id__ins          = if_id_q.ins;
    assign if_id__pc           = if_id_q.pc;
    assign if_id__ins_misalign = if_id_q.misalign;

endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch stage: a directed vector table for the corner cases,
// then a randomized run against an instruction-stream reference model.
module tb_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_flush = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        data_hazard = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_id__ins;
    logic [31:0] if_id__pc;
    logic        if_id__ins_misalign;

    int errors = 0;
    int checks = 0;

    fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pipe_flush          (pipe_flush),
        .jump_target         (jump_target),
        .data_hazard         (data_hazard),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ready          (imem_ready),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .if_id__ins          (if_id__ins),
        .if_id__pc           (if_id__pc),
        .if_id__ins_misalign (if_id__ins_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [31:0] jt;
        logic        dh;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
        logic        exp_mis;
    } vec_t;

    localparam logic [31:0] B  = BUBBLE_PC;
    localparam logic [31:0] N  = NOP_INS;
    localparam logic [31:0] W0 = 32'h1111_1111;
    localparam logic [31:0] W1 = 32'h2222_2222;
    localparam logic [31:0] W2 = 32'h3333_3333;
    localparam logic [31:0] W3 = 32'h4444_4444;
    localparam logic [31:0] W4 = 32'h5555_5555;
    localparam logic [31:0] WX = 32'hdead_beef;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory contents used by the random run: unique per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ 32'h5a5a_0f0f;
    endfunction

    vec_t vq[$];

    // Random-run model state
    logic [31:0] exp_pc;
    logic        trapped;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          words;
    logic        s_req, accepted;
    logic [31:0] s_addr;
    logic [31:0] prev_ins, prev_pc;
    logic        prev_mis;

    initial begin
        // rst flush jt dh ready rvalid rdata | req addr | pc ins mis
        vq.push_back('{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, W0,    1'b0, 32'h0,   32'h0,   W0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, W1,    1'b0, 32'h0,   32'h4,   W1, 1'b0});
        // stall across the response: outputs hold, word lands in the skid buffer
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8,   32'h4,   W1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, W2,    1'b0, 32'h0,   32'h4,   W1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   32'h4,   W1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   32'h8,   W2, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hc,   B,       N,  1'b0});
        // flush while waiting: late response is killed
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hc,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, WX,    1'b0, 32'h0,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, B,       N,  1'b0});
        // flush coincident with rvalid: no kill cycle
        vq.push_back('{1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, W3,    1'b0, 32'h0,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, B,       N,  1'b0});
        // flush in the acceptance cycle: response still owed
        vq.push_back('{1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, W4,    1'b0, 32'h0,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, B,       N,  1'b0});
        // misaligned target: marker once (after a held cycle), then trap bubbles
        vq.push_back('{1'b0, 1'b1, 32'h102, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   32'h102, N,  1'b1});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400, B,       N,  1'b0});
        // reset while waiting
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h400, B,       N,  1'b0});
        vq.push_back('{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   B,       N,  1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0,   B,       N,  1'b0});

        @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            rst         = vq[i].rst;
            pipe_flush  = vq[i].flush;
            jump_target = vq[i].jt;
            data_hazard = vq[i].dh;
            imem_ready  = vq[i].ready;
            imem_rvalid = vq[i].rvalid;
            imem_rdata  = vq[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vq[i].exp_req});
            if (vq[i].exp_req)
                chk($sformatf("v%0d imem_addr", i), imem_addr, vq[i].exp_addr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d if_id__pc", i), if_id__pc, vq[i].exp_pc);
            chk($sformatf("v%0d if_id__ins", i), if_id__ins, vq[i].exp_ins);
            chk($sformatf("v%0d if_id__ins_misalign", i), {31'b0, if_id__ins_misalign}, {31'b0, vq[i].exp_mis});
        end

        // Randomized run: imem responder with variable latency plus stream model.
        exp_pc   = 32'h0;
        trapped  = 1'b0;
        pend     = 1'b0;
        pend_addr = 32'h0;
        pend_cnt = 0;
        words    = 0;
        prev_ins = if_id__ins;
        prev_pc  = if_id__pc;
        prev_mis = if_id__ins_misalign;
        for (int c = 0; c < 4000; c++) begin
            rst         = (c == 0) || ($urandom_range(0, 299) == 0);
            pipe_flush  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0)
                jump_target = {16'h0, 16'($urandom)};
            else
                jump_target = {16'h0, 14'($urandom), 2'b00};
            data_hazard = ($urandom_range(0, 9) < 3);
            imem_ready  = ($urandom_range(0, 9) < 7);
            imem_rvalid = pend && (pend_cnt == 0);
            imem_rdata  = imem_rvalid ? mem_word(pend_addr) : $urandom;
            @(negedge clk);
            s_req  = imem_req;
            s_addr = imem_addr;
            if (rst) begin
                chk("rand req_in_reset", {31'b0, s_req}, 32'h0);
            end else if (trapped || is_misaligned(exp_pc)) begin
                chk("rand req_when_misaligned", {31'b0, s_req}, 32'h0);
            end else if (s_req) begin
                chk("rand imem_addr", s_addr, exp_pc);
                chk("rand one_outstanding", {31'b0, pend && !imem_rvalid}, 32'h0);
            end
            accepted = s_req && imem_ready;
            @(posedge clk);
            #1;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (imem_rvalid)
                    pend = 1'b0;
                else if (pend)
                    pend_cnt--;
                if (accepted) begin
                    pend      = 1'b1;
                    pend_addr = s_addr;
                    pend_cnt  = $urandom_range(0, 2);
                end
            end

            if (rst || pipe_flush) begin
                chk("rand bubble_pc", if_id__pc, B);
                chk("rand bubble_ins", if_id__ins, N);
                chk("rand bubble_mis", {31'b0, if_id__ins_misalign}, 32'h0);
                exp_pc  = rst ? 32'h0 : jump_target;
                trapped = 1'b0;
            end else if (data_hazard) begin
                chk("rand hold_pc", if_id__pc, prev_pc);
                chk("rand hold_ins", if_id__ins, prev_ins);
                chk("rand hold_mis", {31'b0, if_id__ins_misalign}, {31'b0, prev_mis});
            end else if (trapped) begin
                chk("rand trap_bubble", if_id__pc, B);
            end else if (if_id__pc != B || if_id__ins_misalign) begin
                chk("rand word_pc", if_id__pc, exp_pc);
                if (is_misaligned(exp_pc)) begin
                    chk("rand marker_ins", if_id__ins, N);
                    chk("rand marker_mis", {31'b0, if_id__ins_misalign}, 32'h1);
                    trapped = 1'b1;
                end else begin
                    chk("rand word_ins", if_id__ins, mem_word(exp_pc));
                    chk("rand word_mis", {31'b0, if_id__ins_misalign}, 32'h0);
                    exp_pc = exp_pc + 32'd4;
                    words++;
                end
            end else begin
                chk("rand idle_ins", if_id__ins, N);
                chk("rand idle_mis", {31'b0, if_id__ins_misalign}, 32'h0);
            end
            prev_ins = if_id__ins;
            prev_pc  = if_id__pc;
            prev_mis = if_id__ins_misalign;
        end
        checks++;
        if (words < 100) begin
            errors++;
            $display("FAIL rand progress: delivered %0d words, need at least 100", words);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
